// File: rtl/i2c_pkg.sv
// Shared I2C command encodings and sequencer state type used by the
// register sequencer and the byte-level i2c_master it drives.
package i2c_pkg;

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    // Last-byte marker for a single-byte read: the master NACKs it.
    localparam logic [7:0] RD_LAST_BYTE = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        RESP
    } seq_state_t;

endpackage

// File: rtl/i2c_reg_sequencer.sv
// Walks i2c_master through one single-byte register write or read per request,
// aborting to STOP on any NACKed written byte and returning one response.
module i2c_reg_sequencer
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic [2:0] rsp_step,
    output logic [2:0] m_cmd,
    output logic [7:0] m_din,
    output logic       m_wr_i2c,
    input  logic       m_ready,
    input  logic       m_done_tick,
    input  logic       m_ack,
    input  logic [7:0] m_dout
);

    seq_state_t r_state;
    logic       r_rw;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [7:0] r_wdata;
    logic [2:0] r_step;
    logic       r_got_done;
    logic       r_ack;
    logic [2:0] r_m_cmd;
    logic [7:0] r_m_din;
    logic       r_m_wr;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic       r_rsp_nack;
    logic [2:0] r_rsp_step;

    logic [2:0] w_cmd;
    logic [7:0] w_din;
    logic [2:0] w_stop_step;
    logic       w_byte_step;
    logic       w_ack_now;
    logic       w_step_done;

    // Step list decode; indices past the last real step fall through to STOP.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_cmd       = CMD_STOP;
        w_din       = 8'h00;
        w_stop_step = r_rw ? 3'd6 : 3'd4;
        case ({r_rw, r_step})
            4'b0_000: w_cmd = CMD_START;
            4'b0_001: begin w_cmd = CMD_WR; w_din = {r_dev, 1'b0}; end
            4'b0_010: begin w_cmd = CMD_WR; w_din = r_reg;         end
            4'b0_011: begin w_cmd = CMD_WR; w_din = r_wdata;       end
            4'b1_000: w_cmd = CMD_START;
            4'b1_001: begin w_cmd = CMD_WR; w_din = {r_dev, 1'b0}; end
            4'b1_010: begin w_cmd = CMD_WR; w_din = r_reg;         end
            4'b1_011: w_cmd = CMD_RESTART;
            4'b1_100: begin w_cmd = CMD_WR; w_din = {r_dev, 1'b1}; end
            4'b1_101: begin w_cmd = CMD_RD; w_din = RD_LAST_BYTE;  end
            default:  w_cmd = CMD_STOP;
        endcase
    end

    // Byte steps finish on done_tick (possibly the same cycle ready returns);
    // bus-condition steps finish as soon as the master is ready again.
    assign w_byte_step = (r_m_cmd == CMD_WR) || (r_m_cmd == CMD_RD);
    assign w_ack_now   = m_done_tick ? m_ack : r_ack;
    assign w_step_done = m_ready && (!w_byte_step || r_got_done || m_done_tick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rw        <= 1'b0;
            r_dev       <= 7'h00;
            r_reg       <= 8'h00;
            r_wdata     <= 8'h00;
            r_step      <= 3'd0;
            r_got_done  <= 1'b0;
            r_ack       <= 1'b0;
            r_m_cmd     <= CMD_START;
            r_m_din     <= 8'h00;
            r_m_wr      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rsp_nack  <= 1'b0;
            r_rsp_step  <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // branch below sees the pre-edge values of all registers.
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_rw        <= req_rw;
                        r_dev       <= req_dev;
                        r_reg       <= req_reg;
                        r_wdata     <= req_wdata;
                        r_step      <= 3'd0;
                        r_rsp_rdata <= 8'h00;
                        r_rsp_nack  <= 1'b0;
                        r_rsp_step  <= 3'd0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        r_m_cmd <= w_cmd;
                        r_m_din <= w_din;
                        r_m_wr  <= 1'b1;
                        r_state <= GUARD;
                    end
                end
                GUARD: begin
                    // Master still shows ready this cycle; it drops it one cycle later.
                    r_m_wr     <= 1'b0;
                    r_got_done <= 1'b0;
                    r_ack      <= 1'b0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (m_done_tick && w_byte_step) begin
                        r_got_done <= 1'b1;
                        r_ack      <= m_ack;
                        if (r_m_cmd == CMD_RD)
                            r_rsp_rdata <= m_dout;
                    end
                    if (w_step_done) begin
                        if (r_m_cmd == CMD_STOP) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_state <= ISSUE;
                            if (r_m_cmd == CMD_WR && w_ack_now) begin
                                r_rsp_nack <= 1'b1;
                                r_rsp_step <= r_step;
                                r_step     <= w_stop_step;
                            end else begin
                                r_step <= r_step + 3'd1;
                            end
                        end
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_nack  = r_rsp_nack;
    assign rsp_step  = r_rsp_step;
    assign m_cmd     = r_m_cmd;
    assign m_din     = r_m_din;
    assign m_wr_i2c  = r_m_wr;

endmodule
